// File: rtl/aes_key_reverser.sv
// aes_key_reverser: AES-256 inverse key schedule, emits round keys 14 down to 0 from the RK13/RK14 window.
// Words and bytes are little-endian: word 0 at [31:0], byte 0 of each word at [7:0].
module aes_sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254, then the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] x2, x3, x12, x15, x240, v;
        x2 = gmul(a, a);
        x3 = gmul(x2, a);
        x12 = gmul(gmul(x3, x3), gmul(x3, x3));
        x15 = gmul(x12, x3);
        x240 = gmul(x15, x15);
        x240 = gmul(x240, x240);
        x240 = gmul(x240, x240);
        x240 = gmul(x240, x240);
        v = gmul(gmul(x240, x12), x2);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    assign out_o = sbox(in_i);
endmodule

module aes_key_reverser (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clear_i,
    input  logic         key_valid_i,
    output logic         key_ready_o,
    input  logic [255:0] final_key_i,
    output logic         round_key_valid_o,
    input  logic         round_key_ready_i,
    output logic [127:0] round_key_o,
    output logic [3:0]   round_index_o,
    output logic         last_o
);
    localparam int KEY_W = 256;
    localparam int BLK_W = 128;
    localparam int WORD_W = 32;

    typedef enum logic {IDLE, EMIT} state_t;

    state_t             state_q, state_d;
    logic [KEY_W-1:0]   win_q, win_d;
    logic [3:0]         idx_q, idx_d;
    logic [WORD_W-1:0]  w7, w8, w9, w10, w11, sb_in, sb_out, f_w;
    logic [7:0]         rc;
    logic               even;
    logic [BLK_W-1:0]   prev_rk;

    assign w7  = win_q[4*WORD_W-1:3*WORD_W];
    assign w8  = win_q[5*WORD_W-1:4*WORD_W];
    assign w9  = win_q[6*WORD_W-1:5*WORD_W];
    assign w10 = win_q[7*WORD_W-1:6*WORD_W];
    assign w11 = win_q[8*WORD_W-1:7*WORD_W];
    assign even = ~idx_q[0];
    assign sb_in = even ? {w7[7:0], w7[31:8]} : w7;
    assign rc = even ? 8'(8'h01 << (idx_q[3:1] - 3'd1)) : 8'h00;
    assign f_w = sb_out ^ {24'h0, rc};
    assign prev_rk = idx_q == 4'd1 ? '0 : {w11 ^ w10, w10 ^ w9, w9 ^ w8, w8 ^ f_w};

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (.in_i(sb_in[8*b +: 8]), .out_o(sb_out[8*b +: 8]));
    end

    always_comb begin
        state_d = state_q;
        win_d = win_q;
        idx_d = idx_q;
        if (clear_i) begin
            state_d = IDLE;
        end else if (state_q == IDLE && key_valid_i) begin
            state_d = EMIT;
            win_d = final_key_i;
            idx_d = 4'd14;
        end else if (state_q == EMIT && round_key_ready_i) begin
            state_d = idx_q == 4'd0 ? IDLE : EMIT;
            win_d = idx_q == 4'd0 ? win_q : {win_q[BLK_W-1:0], prev_rk};
            idx_d = idx_q == 4'd0 ? idx_q : idx_q - 4'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            win_q <= '0;
            idx_q <= '0;
        end else begin
            state_q <= state_d;
            win_q <= win_d;
            idx_q <= idx_d;
        end
    end

    assign key_ready_o = state_q == IDLE;
    assign round_key_valid_o = state_q == EMIT;
    assign round_key_o = win_q[KEY_W-1:BLK_W];
    assign round_index_o = idx_q;
    assign last_o = state_q == EMIT && idx_q == 4'd0;
endmodule
